// File: rtl/fft_twiddle_mult.sv
// Pipelined complex twiddle multiplier for one radix-2^2 SDF stage.
// It holds its own sample counter and twiddle ROM, and has three register stages: operand/ROM, products, and round/saturate.
module fft_twiddle_mult #(
  parameter int DATA_WIDTH = 16,
  parameter int TW_WIDTH   = 16,
  parameter int N_POINTS   = 16,
  parameter int STAGE      = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clr,
  input  logic                         in_val,
  input  logic signed [DATA_WIDTH-1:0] a_re,
  input  logic signed [DATA_WIDTH-1:0] a_im,
  output logic                         out_val,
  output logic signed [DATA_WIDTH-1:0] b_re,
  output logic signed [DATA_WIDTH-1:0] b_im
);

  localparam int  L        = N_POINTS >> (2 * STAGE);
  localparam int  CNT_BITS = $clog2(L);
  localparam int  M_BITS   = CNT_BITS - 2;
  localparam int  E_BITS   = $clog2(N_POINTS);
  localparam int  PW       = DATA_WIDTH + TW_WIDTH;
  localparam int  SW       = PW + 1;
  localparam int  FRAC     = TW_WIDTH - 2;
  localparam real PI       = 3.14159265358979323846;

  localparam logic signed [SW-1:0] RND    = SW'(1 << (FRAC - 1));
  localparam logic signed [SW-1:0] SAT_HI = SW'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_LO = ~SAT_HI;

  // Elaboration-time trig: the angle is folded into [-pi, pi] so the Taylor series stays accurate.
  function automatic real wrap_angle(input int e);
    real x;
    x = 2.0 * PI * real'(e) / real'(N_POINTS);
    if (x > PI) x = x - 2.0 * PI;
    return x;
  endfunction

  function automatic real cos_t(input real x);
    real term, sum;
    term = 1.0;
    sum  = 1.0;
    for (int i = 1; i <= 20; i++) begin
      term = -term * x * x / real'((2 * i - 1) * (2 * i));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic real sin_t(input real x);
    real term, sum;
    term = x;
    sum  = x;
    for (int i = 1; i <= 20; i++) begin
      term = -term * x * x / real'((2 * i) * (2 * i + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic logic signed [TW_WIDTH-1:0] to_q(input real v);
    real s;
    s = v * real'(1 << FRAC);
    if (s >= 0.0) return TW_WIDTH'($rtoi(s + 0.5));
    return TW_WIDTH'(-$rtoi(-s + 0.5));
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] round_sat(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] r;
    r = (s + RND) >>> FRAC;
    if (r > SAT_HI) return SAT_HI[DATA_WIDTH-1:0];
    if (r < SAT_LO) return SAT_LO[DATA_WIDTH-1:0];
    return r[DATA_WIDTH-1:0];
  endfunction

  logic signed [TW_WIDTH-1:0] rom_re [N_POINTS];
  logic signed [TW_WIDTH-1:0] rom_im [N_POINTS];

  for (genvar g = 0; g < N_POINTS; g++) begin : g_rom
    assign rom_re[g] = to_q(cos_t(wrap_angle(g)));
    assign rom_im[g] = to_q(-sin_t(wrap_angle(g)));
  end

  logic [CNT_BITS-1:0]          n_q, n_d;
  logic                         v1_q, v1_d, v2_q, v2_d, out_val_q, out_val_d;
  logic signed [DATA_WIDTH-1:0] a_re_q, a_re_d, a_im_q, a_im_d;
  logic signed [TW_WIDTH-1:0]   w_re_q, w_re_d, w_im_q, w_im_d;
  logic signed [PW-1:0]         p_rr_q, p_rr_d, p_ii_q, p_ii_d;
  logic signed [PW-1:0]         p_ri_q, p_ri_d, p_ir_q, p_ir_d;
  logic signed [DATA_WIDTH-1:0] b_re_q, b_re_d, b_im_q, b_im_d;

  // Exponent e = 4^STAGE * k(q) * m, where k is the bit-reversed quarter index.
  logic [1:0]          quarter;
  logic [CNT_BITS-1:0] k_ext, m_ext, km;
  logic [E_BITS-1:0]   e;

  always_comb begin
    quarter = n_q[CNT_BITS-1 -: 2];
    k_ext   = CNT_BITS'({quarter[0], quarter[1]});
    m_ext   = CNT_BITS'(n_q[M_BITS-1:0]);
    km      = k_ext * m_ext;
    e       = E_BITS'(km) << (2 * STAGE);
  end

  always_comb begin
    // NOTE: every _d starts as its _q, so a path that assigns nothing holds state instead of inferring a latch.
    n_d       = n_q;
    v1_d      = v1_q;
    v2_d      = v2_q;
    out_val_d = out_val_q;
    a_re_d    = a_re_q;
    a_im_d    = a_im_q;
    w_re_d    = w_re_q;
    w_im_d    = w_im_q;
    p_rr_d    = p_rr_q;
    p_ii_d    = p_ii_q;
    p_ri_d    = p_ri_q;
    p_ir_d    = p_ir_q;
    b_re_d    = b_re_q;
    b_im_d    = b_im_q;

    if (en) begin
      if (clr) begin
        n_d       = '0;
        v1_d      = 1'b0;
        v2_d      = 1'b0;
        out_val_d = 1'b0;
      end else begin
        v1_d = in_val;
        if (in_val) begin
          n_d    = n_q + CNT_BITS'(1);
          a_re_d = a_re;
          a_im_d = a_im;
          w_re_d = rom_re[e];
          w_im_d = rom_im[e];
        end

        v2_d = v1_q;
        if (v1_q) begin
          p_rr_d = PW'(a_re_q) * PW'(w_re_q);
          p_ii_d = PW'(a_im_q) * PW'(w_im_q);
          p_ri_d = PW'(a_re_q) * PW'(w_im_q);
          p_ir_d = PW'(a_im_q) * PW'(w_re_q);
        end

        // Bubbles leave b_re/b_im untouched; only out_val follows them.
        out_val_d = v2_q;
        if (v2_q) begin
          b_re_d = round_sat(SW'(p_rr_q) - SW'(p_ii_q));
          b_im_d = round_sat(SW'(p_ri_q) + SW'(p_ir_q));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q       <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      out_val_q <= 1'b0;
      a_re_q    <= '0;
      a_im_q    <= '0;
      w_re_q    <= '0;
      w_im_q    <= '0;
      p_rr_q    <= '0;
      p_ii_q    <= '0;
      p_ri_q    <= '0;
      p_ir_q    <= '0;
      b_re_q    <= '0;
      b_im_q    <= '0;
    end else begin
      // NOTE: non-blocking updates so every stage samples the previous stage's pre-edge value.
      n_q       <= n_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      out_val_q <= out_val_d;
      a_re_q    <= a_re_d;
      a_im_q    <= a_im_d;
      w_re_q    <= w_re_d;
      w_im_q    <= w_im_d;
      p_rr_q    <= p_rr_d;
      p_ii_q    <= p_ii_d;
      p_ri_q    <= p_ri_d;
      p_ir_q    <= p_ir_d;
      b_re_q    <= b_re_d;
      b_im_q    <= b_im_d;
    end
  end

  assign out_val = out_val_q;
  assign b_re    = b_re_q;
  assign b_im    = b_im_q;

endmodule

// File: tb/tb_fft_twiddle_mult.sv
// Directed bench for fft_twiddle_mult: a STAGE=0/N=16 and a STAGE=1/N=64 instance share one stimulus stream.
// The expected twiddle products for a 1000+j0 input are a hand-computed table.
module tb_fft_twiddle_mult;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n, en, clr, in_val;
  logic signed [DW-1:0] a_re, a_im;
  logic ov0, ov1;
  logic signed [DW-1:0] br0, bi0, br1, bi1;

  int n_checks = 0;
  int n_errors = 0;

  // Output for sample n of a 1000+j0 frame. The table is identical for both instances,
  // because STAGE=1/N=64 uses 4x the exponent over a 4x larger N.
  int exp_re [16] = '{1000, 1000, 1000, 1000, 1000,  707,     0, -707,
                      1000,  924,  707,  383, 1000,  383,  -707, -924};
  int exp_im [16] = '{   0,    0,    0,    0,    0, -707, -1000, -707,
                         0, -383, -707, -924,    0, -924,  -707,  383};

  int got_re0 [32], got_im0 [32], got_re1 [32], got_im1 [32];
  int gj0 = 0, gj1 = 0;

  fft_twiddle_mult #(.DATA_WIDTH(16), .TW_WIDTH(16), .N_POINTS(16), .STAGE(0)) u_stage0 (
    .clk(clk), .rst(rst_n), .en(en), .clr(clr), .in_val(in_val),
    .a_re(a_re), .a_im(a_im), .out_val(ov0), .b_re(br0), .b_im(bi0)
  );

  fft_twiddle_mult #(.DATA_WIDTH(16), .TW_WIDTH(16), .N_POINTS(64), .STAGE(1)) u_stage1 (
    .clk(clk), .rst(rst_n), .en(en), .clr(clr), .in_val(in_val),
    .a_re(a_re), .a_im(a_im), .out_val(ov1), .b_re(br1), .b_im(bi1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Present one input for one clock; returns 1 time unit after the edge.
  task automatic cyc(input logic v, input int re, input int im);
    in_val = v;
    a_re   = DW'(re);
    a_im   = DW'(im);
    @(posedge clk);
    #1;
  endtask

  task automatic collect();
    if (ov0 && gj0 < 32) begin
      got_re0[gj0] = br0;
      got_im0[gj0] = bi0;
      gj0++;
    end
    if (ov1 && gj1 < 32) begin
      got_re1[gj1] = br1;
      got_im1[gj1] = bi1;
      gj1++;
    end
  endtask

  task automatic do_reset();
    en     = 1'b1;
    clr    = 1'b0;
    in_val = 1'b0;
    rst_n  = 1'b0;
    #1;
    rst_n  = 1'b1;
    gj0    = 0;
    gj1    = 0;
  endtask

  task automatic cmp_table0(input string tag);
    for (int j = 0; j < 16; j++) begin
      check($sformatf("%s_re%0d", tag, j), got_re0[j], exp_re[j]);
      check($sformatf("%s_im%0d", tag, j), got_im0[j], exp_im[j]);
    end
  endtask

  initial begin
    int mism;
    int hold_bad;
    int snap_ov, snap_re, snap_im;
    logic exp_ov;

    rst_n  = 1'b0;
    en     = 1'b1;
    clr    = 1'b0;
    in_val = 1'b0;
    a_re   = '0;
    a_im   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_val", ov0, 0);
    check("reset_b_re", br0, 0);
    check("reset_b_im", bi0, 0);
    rst_n = 1'b1;

    // Full frame of 1000+j0 on both instances.
    mism = 0;
    for (int k = 0; k < 19; k++) begin
      cyc(k < 16, 1000, 0);
      exp_ov = (k >= 2) && (k <= 17);
      if (ov0 !== exp_ov) mism++;
      if (ov1 !== exp_ov) mism++;
      collect();
    end
    check("frame_out_val_pattern", mism, 0);
    check("frame_count_s0", gj0, 16);
    check("frame_count_s1", gj1, 16);
    cmp_table0("frame_s0");
    for (int j = 0; j < 16; j++) begin
      check($sformatf("frame_s1_re%0d", j), got_re1[j], exp_re[j]);
      check($sformatf("frame_s1_im%0d", j), got_im1[j], exp_im[j]);
    end

    // Saturation at n=6 (e=4, W = -j).
    do_reset();
    for (int k = 0; k < 6; k++) cyc(1'b1, 0, 0);
    cyc(1'b1, -32768, -32768);
    cyc(1'b0, 0, 0);
    cyc(1'b0, 0, 0);
    check("sat_out_val", ov0, 1);
    check("sat_b_re", br0, -32768);
    check("sat_b_im", bi0, 32767);

    // Asynchronous reset in mid-stream.
    do_reset();
    for (int k = 0; k < 7; k++) cyc(1'b1, 1000, 0);
    check("pre_reset_out_val", ov0, 1);
    check("pre_reset_b_re", br0, 1000);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out_val", ov0, 0);
    check("async_reset_b_re", br0, 0);
    check("async_reset_b_im", bi0, 0);
    rst_n = 1'b1;
    cyc(1'b1, 1234, -567);
    cyc(1'b0, 0, 0);
    cyc(1'b0, 0, 0);
    check("post_reset_out_val", ov0, 1);
    check("post_reset_b_re", br0, 1234);
    check("post_reset_b_im", bi0, -567);

    // Alternating bubbles.
    do_reset();
    mism     = 0;
    hold_bad = 0;
    for (int k = 0; k < 35; k++) begin
      cyc((k < 32) && (k % 2 == 0), 1000, 0);
      exp_ov = (k >= 2) && (k <= 32) && (k % 2 == 0);
      if (ov0 !== exp_ov) mism++;
      if (ov0) collect();
      else if (gj0 > 0 && (int'(br0) != got_re0[gj0-1] || int'(bi0) != got_im0[gj0-1])) hold_bad++;
    end
    check("bubble_out_val_pattern", mism, 0);
    check("bubble_hold", hold_bad, 0);
    check("bubble_count", gj0, 16);
    cmp_table0("bubble");

    // Five-cycle stall with en=0, including a clr that must be ignored.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1000, 0);
      collect();
    end
    snap_ov = ov0;
    snap_re = br0;
    snap_im = bi0;
    check("stall_pre_out_val", snap_ov, 1);
    en   = 1'b0;
    mism = 0;
    for (int s = 0; s < 5; s++) begin
      clr = (s == 2);
      cyc(1'b1, 7777, -7777);
      if (int'(ov0) != snap_ov || int'(br0) != snap_re || int'(bi0) != snap_im) mism++;
    end
    clr = 1'b0;
    en  = 1'b1;
    check("stall_frozen", mism, 0);
    for (int k = 6; k < 16; k++) begin
      cyc(1'b1, 1000, 0);
      collect();
    end
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 0, 0);
      collect();
    end
    check("stall_count", gj0, 16);
    cmp_table0("stall");

    // Counter wrap after 16 samples, then clr.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      if (k < 16) cyc(1'b1, 1000, 0);
      else        cyc(1'b1, 500 + k, -200 - k);
      collect();
    end
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 0, 0);
      collect();
    end
    check("wrap_count", gj0, 20);
    cmp_table0("wrap");
    for (int j = 16; j < 20; j++) begin
      check($sformatf("wrap_pass_re%0d", j), got_re0[j], 500 + j);
      check($sformatf("wrap_pass_im%0d", j), got_im0[j], -200 - j);
    end
    cyc(1'b1, 11, 22);
    cyc(1'b1, 33, 44);
    clr = 1'b1;
    cyc(1'b1, 55, 66);
    clr = 1'b0;
    check("clr_out_val", ov0, 0);
    check("clr_hold_b_re", br0, 519);
    check("clr_hold_b_im", bi0, -219);
    cyc(1'b1, 1234, -567);
    check("clr_no_ghost1", ov0, 0);
    cyc(1'b0, 0, 0);
    check("clr_no_ghost2", ov0, 0);
    cyc(1'b0, 0, 0);
    check("clr_first_out_val", ov0, 1);
    check("clr_first_b_re", br0, 1234);
    check("clr_first_b_im", bi0, -567);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
